// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
//   Bundles the instruction-memory and decode-side signals of the fetch unit.
//
//   Signals (direction as seen from the fetch unit, i.e. the master modport):
//     rom_addr        out  word address into the combinational instruction ROM
//     rom_data        in   ROM word for rom_addr, valid in the same cycle
//     if_valid        out  prefetch FIFO head holds an instruction
//     if_ready        in   decode accepts the head
//     if_instr        out  head instruction
//     if_pc           out  word address of the head instruction
//     redirect_valid  in   one-cycle branch/jump request
//     redirect_addr   in   redirect target word address
//     halted          out  halt word fetched, fetching stopped
//
//   master : the fetch unit
//   slave  : the environment (ROM, decode, execute)

interface instr_fetch_unit_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);

   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              if_valid;
   logic              if_ready;
   logic [DATA_W-1:0] if_instr;
   logic [ADDR_W-1:0] if_pc;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_addr;
   logic              halted;

   modport master (
      output rom_addr,
      input  rom_data,
      output if_valid,
      input  if_ready,
      output if_instr,
      output if_pc,
      input  redirect_valid,
      input  redirect_addr,
      output halted
   );

   modport slave (
      input  rom_addr,
      output rom_data,
      input  if_valid,
      output if_ready,
      input  if_instr,
      input  if_pc,
      output redirect_valid,
      output redirect_addr,
      input  halted
   );

endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Initiator side of the instruction-memory interface. Owns the fetch PC,
//   drives it straight onto the ROM address, and pushes {pc, word} into a
//   small prefetch FIFO that decode drains over a valid/ready handshake.
//   Execute can redirect the PC (flushing the FIFO); fetching stops once the
//   halt word has been pushed, until the next redirect.
//
//   Ports:
//     clk           system clock, rising edge
//     rst_n         asynchronous active-low reset
//     bus           instr_fetch_unit_if.master (ROM, decode and redirect signals)
//   Optional ports (only when the FETCH_PERF_EN macro is defined):
//     fetch_count   saturating count of instructions accepted by decode
//     bubble_count  saturating count of cycles with nothing to offer while
//                   not halted
//
//   Build option: FETCH_PERF_EN adds the two performance counters above.

module instr_fetch_unit #(
   parameter int                 ADDR_W     = 16,
   parameter int                 DATA_W     = 32,
   parameter int                 FIFO_DEPTH = 2,
   parameter logic [DATA_W-1:0]  HALT_WORD  = 32'hD60003E0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   instr_fetch_unit_if.master    bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]           fetch_count,
   output logic [31:0]           bubble_count
`endif
);

   localparam int               PTR_W   = $clog2(FIFO_DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic [ADDR_W-1:0] fpc;
   logic              halted_q;

   logic [DATA_W-1:0] mem_instr [FIFO_DEPTH];
   logic [ADDR_W-1:0] mem_pc    [FIFO_DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;

   // Registered copy of the head entry; it only moves when the head moves,
   // so it holds its last value while the FIFO is empty.
   logic [DATA_W-1:0] head_instr;
   logic [ADDR_W-1:0] head_pc;

   logic              pop;
   logic              push;
   logic              redirect;
   logic              halt_hit;
   logic [PTR_W-1:0]  head_nxt;
   logic [CNT_W-1:0]  cnt_after_pop;

   always_comb begin
      redirect      = bus.redirect_valid;
      pop           = (count != '0) && bus.if_ready;
      push          = !halted_q && !redirect && ((count < DEPTH_C) || pop);
      halt_hit      = push && (bus.rom_data == HALT_WORD);
      head_nxt      = pop ? head + PTR_W'(1) : head;
      cnt_after_pop = pop ? count - CNT_W'(1) : count;
   end

   // fetch PC and halt flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpc      <= '0;
         halted_q <= 1'b0;
      end else if (redirect) begin
         fpc      <= bus.redirect_addr;
         halted_q <= 1'b0;
      end else if (push) begin
         fpc <= fpc + ADDR_W'(1);
         if (halt_hit) begin
            halted_q <= 1'b1;
         end
      end
   end

   // FIFO storage and pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_instr[i] <= '0;
            mem_pc[i]    <= '0;
         end
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (redirect) begin
         // A concurrent pop is simply absorbed by the flush.
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem_instr[tail] <= bus.rom_data;
            mem_pc[tail]    <= fpc;
            tail            <= tail + PTR_W'(1);
         end
         head <= head_nxt;
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // head output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_instr <= '0;
         head_pc    <= '0;
      end else if (!redirect) begin
         if (push && (cnt_after_pop == '0)) begin
            // FIFO empty (or just emptied): the incoming word becomes the head.
            head_instr <= bus.rom_data;
            head_pc    <= fpc;
         end else if (pop && (cnt_after_pop != '0)) begin
            head_instr <= mem_instr[head_nxt];
            head_pc    <= mem_pc[head_nxt];
         end
      end
   end

   assign bus.rom_addr = fpc;
   assign bus.if_valid = (count != '0);
   assign bus.if_instr = head_instr;
   assign bus.if_pc    = head_pc;
   assign bus.halted   = halted_q;

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count  <= '0;
         bubble_count <= '0;
      end else begin
         if (pop && (fetch_count != '1)) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if ((count == '0) && !halted_q && (bubble_count != '1)) begin
            bubble_count <= bubble_count + 32'd1;
         end
      end
   end
`endif

endmodule
